reg_xfer_bank: RTL and testbench

REG_XFER_BANK -- requirements
Module: reg_xfer_bank

---
 rtl/reg_xfer_bank.sv | 99 +++++++++
 tb/tb_reg_xfer_bank.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/reg_xfer_bank.sv
// reg_xfer_bank: pushbutton-driven register bank (clear/load/shift/push) with hex display.
// Define REG_XFER_BANK_DEBOUNCE_EN to add per-key debounce of DEBOUNCE_CYCLES stable samples.
module reg_xfer_bank #(
  parameter int WIDTH           = 16,
  parameter int DEPTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           din,
  input  logic [2:0]                 KEY,
  input  logic [$clog2(DEPTH)-1:0]   sel,
  output logic [WIDTH-1:0]           q,
  output logic [7*WIDTH/4-1:0]       HEX,
  output logic                       busy,
  output logic [7:0]                 op_count
);
  localparam int ND = WIDTH / 4;
  typedef enum logic {IDLE, HOLD} state_t;
  state_t           r_state;
  logic [2:0]       r_s1, r_s2, w_k, w_p;
  logic [WIDTH-1:0] r_reg [DEPTH];
`ifdef REG_XFER_BANK_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [2:0]    r_db, w_done;
  logic [CW-1:0] r_cnt [3];
  // The sample that completes the stable run is accepted the same edge it is counted.
  always_comb begin
    for (int i = 0; i < 3; i++)
      w_done[i] = (r_s2[i] != r_db[i]) && (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1));
    w_k = (r_db & ~w_done) | (r_s2 & w_done);
  end
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_db <= '1;
      for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (r_s2[i] == r_db[i]) r_cnt[i] <= '0;
        else if (w_done[i]) begin
          r_db[i]  <= r_s2[i];
          r_cnt[i] <= '0;
        end else r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end
`else
  assign w_k = r_s2;
`endif
  assign w_p  = ~w_k;
  assign busy = (r_state == HOLD);
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_s1     <= '1;
      r_s2     <= '1;
      r_state  <= IDLE;
      op_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_reg[i] <= '0;
    end else begin
      r_s1 <= KEY;
      r_s2 <= r_s1;
      if (r_state == IDLE && |w_p) begin
        r_state <= HOLD;
        if (w_p[0]) begin
          op_count <= '0;
          for (int i = 0; i < DEPTH; i++) r_reg[i] <= '0;
        end else begin
          if (w_p[2]) for (int i = 1; i < DEPTH; i++) r_reg[i] <= r_reg[i-1];
          r_reg[0] <= w_p[1] ? din : '0;
          op_count <= op_count + 1'b1;
        end
      end else if (r_state == HOLD && &w_k) r_state <= IDLE;
    end
  end
  assign q = (32'(sel) < DEPTH) ? r_reg[sel] : '0;
  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
  endfunction
  for (genvar g = 0; g < ND; g++) begin : g_hex
    assign HEX[7*g +: 7] = seg(q[4*g +: 4]);
  end
endmodule

// File: tb/tb_reg_xfer_bank.sv
// tb_reg_xfer_bank: random key operations against an array model; a monitor checks each executed op.
module tb_reg_xfer_bank;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] din = '0;
  logic [2:0]  key = 3'b111;
  logic [1:0]  sel = '0;
  logic [15:0] q;
  logic [27:0] hex;
  logic        busy;
  logic [7:0]  op_count;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  typedef struct packed {
    logic [3:0][15:0] r;
    logic [7:0]       cnt;
    logic [31:0]      cyc;
  } exp_t;
  exp_t sb[$];
  logic [3:0][15:0] m = '0;
  int mcnt = 0;

  reg_xfer_bank dut (
    .CLOCK_50(clk), .reset(rst), .din(din), .KEY(key), .sel(sel),
    .q(q), .HEX(hex), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
  endfunction

  function automatic logic [27:0] hex_of(input logic [15:0] v);
    logic [27:0] h;
    for (int d = 0; d < 4; d++) h[7*d +: 7] = seg(v[4*d +: 4]);
    return h;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference behaviour: clear wins; shift moves every register up one; load/push fills R[0].
  task automatic apply(input logic [2:0] p, input logic [15:0] d);
    if (p[0]) begin
      m = '0;
      mcnt = 0;
    end else if (p[1] || p[2]) begin
      if (p[2]) begin
        for (int i = 3; i > 0; i--) m[i] = m[i-1];
        m[0] = 16'h0000;
      end
      if (p[1]) m[0] = d;
      mcnt = (mcnt + 1) % 256;
    end
  endtask

  task automatic push_exp(input int c);
    exp_t e;
    e.r   = m;
    e.cnt = 8'(mcnt);
    e.cyc = 32'(c);
    sb.push_back(e);
  endtask

  task automatic wait_busy(input logic v);
    int n;
    for (n = 0; n < 40 && busy !== v; n++) @(negedge clk);
    if (busy !== v) begin
      checks++;
      errors++;
      $display("FAIL busy_wait got=%0b want=%0b (cycle %0d)", busy, v, cyc);
    end
  endtask

  task automatic do_op(input logic [2:0] p, input int hold, input logic [2:0] extra, input logic [15:0] d);
    @(negedge clk);
    din = d;
    key = ~p;
    apply(p, d);
    push_exp(cyc + 3);
    wait_busy(1'b1);
    key = ~(p | extra);
    repeat (hold) @(negedge clk);
    key = 3'b111;
    wait_busy(1'b0);
    @(negedge clk);
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, "_q"}, q, 0);
    chk({nm, "_hex"}, hex, hex_of(16'h0000));
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_opc"}, op_count, 0);
  endtask

  // Monitor: every IDLE->HOLD transition is one executed operation.
  initial begin
    logic pb;
    logic b;
    exp_t e;
    pb = 1'b0;
    forever begin
      @(negedge clk);
      b = busy;
      if (b && !pb) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_op got=op want=none (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("op_cycle", 64'(cyc), 64'(e.cyc));
          chk("op_count", op_count, e.cnt);
          for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            chk("q", q, e.r[s]);
            chk("hex", hex, hex_of(e.r[s]));
          end
        end
      end
      pb = b;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] p;
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    do_op(3'b010, 3, 3'b000, 16'hBEEF);
    for (int v = 1; v <= 4; v++) do_op(3'b110, 1, 3'b000, 16'(v));
    do_op(3'b100, 1, 3'b000, 16'h1234);
    do_op(3'b100, 100, 3'b010, 16'h5A5A);
    do_op(3'b011, 2, 3'b000, 16'hFFFF);
    for (int i = 0; i < 256; i++) do_op(3'b010, 0, 3'b000, 16'($urandom));
    for (int i = 0; i < 150; i++) begin
      p = 3'($urandom_range(1, 7));
      if (p[0] && $urandom_range(0, 3) != 0) p[0] = 1'b0;
      if (p == 3'b000) p = 3'b010;
      do_op(p, $urandom_range(0, 6), 3'($urandom), 16'($urandom));
    end
    // Reset in the middle of a held key, then the same key counts as a fresh press.
    @(negedge clk);
    key = ~3'b100;
    apply(3'b100, din);
    push_exp(cyc + 3);
    wait_busy(1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_state("midhold");
    m = '0;
    mcnt = 0;
    @(negedge clk);
    rst = 1'b0;
    apply(3'b100, din);
    push_exp(cyc + 3);
    wait_busy(1'b1);
    key = 3'b111;
    wait_busy(1'b0);
    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 0);
    chk("final_opc", op_count, 64'(mcnt));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
